// File: rtl/pwm_multi_ramp.sv
// Multi-channel PWM: one shared frame counter, per-channel target/active duty, updates at frame boundaries.
// Optional macro PWM_RAMP_EN: active duty slews toward target by at most RAMP_STEP per frame.
module pwm_multi_ramp #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PERIOD_RST = 255,
  parameter int RAMP_STEP  = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [WIDTH-1:0]    period,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_chan,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm,
  output logic                frame_start,
  output logic [CHANNELS-1:0] settled
);

  localparam logic [CW:0] CHAN_LIM = (CW + 1)'(CHANNELS);

  if (CHANNELS < 1 || CHANNELS > 16 || RAMP_STEP < 1) begin : g_param_check
    $error("pwm_multi_ramp: parameter out of range");
  end

  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] target      [CHANNELS];
  logic [WIDTH-1:0] active      [CHANNELS];
  logic [WIDTH-1:0] next_active [CHANNELS];
  logic             boundary;
  logic             wr_ok;

  assign boundary    = enable && (counter == period_q);
  assign wr_ok       = wr_en && ({1'b0, wr_chan} < CHAN_LIM);
  assign frame_start = enable && (counter == '0);

`ifdef PWM_RAMP_EN
  localparam logic [WIDTH-1:0] STEP = WIDTH'(RAMP_STEP);
`endif

  // Duty each channel adopts at the next boundary; with ramping it never overshoots the target.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      next_active[i] = target[i];
`ifdef PWM_RAMP_EN
      if (target[i] > active[i]) begin
        if (target[i] - active[i] > STEP) next_active[i] = active[i] + STEP;
      end else if (active[i] - target[i] > STEP) begin
        next_active[i] = active[i] - STEP;
      end
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      settled[i] = (active[i] == target[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      counter  <= '0;
      period_q <= WIDTH'(PERIOD_RST);
      pwm      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_ok) target[wr_chan] <= wr_duty;
      if (!enable) begin
        counter  <= '0;
        period_q <= period;
        pwm      <= '0;
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          pwm[i] <= (counter < active[i]);
        end
        // Active duty loads from the pre-edge target, so a write in the boundary cycle waits a frame.
        if (boundary) begin
          counter  <= '0;
          period_q <= period;
          for (int i = 0; i < CHANNELS; i++) begin
            active[i] <= next_active[i];
          end
        end else begin
          counter <= counter + 1'b1;
        end
      end
    end
  end

endmodule
